lsu_mem_ctrl: RTL and testbench

- Load/store controller sitting directly upstream of data_memory in the MEM stage.
- Accepts one RV32I load/store per handshake from the EX/MEM pipeline register and performs range, alignment and funct3 checks.
- Drives word-aligned accesses on data_memory's single read/write port and performs read-modify-write for SB/SH, since data_memory has no byte strobes.
- Extracts and sign/zero-extends load data and returns a one-cycle response to write-back.

---
 rtl/lsu_mem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller in front of a word-wide, strobe-less data memory.
// Checks each request, does read-modify-write for SB/SH and extends load data.
module lsu_mem_ctrl #(
   parameter int unsigned DROM_SPACE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic [1:0]  resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_r_en,
   output logic        mem_w_en,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      StIdle,
      StLdRd,
      StLdCap,
      StRmwRd,
      StRmwMrg,
      StStWr,
      StResp
   } state_e;

   localparam logic [1:0] ErrOk       = 2'b00;
   localparam logic [1:0] ErrMisalign = 2'b01;
   localparam logic [1:0] ErrRange    = 2'b10;
   localparam logic [1:0] ErrFunct3   = 2'b11;

   state_e      r_state;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [15:0] r_wdata;
   logic [4:0]  r_rd;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic [4:0]  r_resp_rd;
   logic [1:0]  r_resp_err;
   logic [31:0] r_mem_wdata;
   logic        r_mem_r_en;
   logic        r_mem_w_en;

   logic        w_illegal;
   logic        w_misalign;
   logic        w_oor;
   logic [32:0] w_end;
   logic [1:0]  w_err;
   logic [15:0] w_lane;
   logic [31:0] w_load;
   logic [31:0] w_merge;

   // Request checks, evaluated on the live request while in IDLE
   always_comb begin
      w_illegal = 1'b1;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
         3'b100, 3'b101:         w_illegal = req_we;
         default:                w_illegal = 1'b1;
      endcase
      w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      // 33-bit sum so addresses near 2^32 cannot wrap into range
      w_end = {1'b0, req_addr[31:2], 2'b00} + 33'd3;
      w_oor = w_end > 33'(DROM_SPACE - 1);
      if (w_illegal) begin
         w_err = ErrFunct3;
      end else if (w_misalign) begin
         w_err = ErrMisalign;
      end else if (w_oor) begin
         w_err = ErrRange;
      end else begin
         w_err = ErrOk;
      end
   end

   // Load lane select and extension
   always_comb begin
      w_lane = 16'(mem_rdata >> {r_addr[1:0], 3'b000});
      w_load = mem_rdata;
      case (r_funct3)
         3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
         3'b001:  w_load = {{16{w_lane[15]}}, w_lane};
         3'b100:  w_load = {24'd0, w_lane[7:0]};
         3'b101:  w_load = {16'd0, w_lane};
         default: w_load = mem_rdata;
      endcase
   end

   // Sub-word store merge onto the word just read
   always_comb begin
      w_merge = mem_rdata;
      if (r_funct3[1:0] == 2'b00) begin
         case (r_addr[1:0])
            2'b00:   w_merge[7:0]   = r_wdata[7:0];
            2'b01:   w_merge[15:8]  = r_wdata[7:0];
            2'b10:   w_merge[23:16] = r_wdata[7:0];
            default: w_merge[31:24] = r_wdata[7:0];
         endcase
      end else if (r_addr[1]) begin
         w_merge[31:16] = r_wdata;
      end else begin
         w_merge[15:0] = r_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_funct3     <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rd         <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_rd    <= '0;
         r_resp_err   <= '0;
         r_mem_wdata  <= '0;
         r_mem_r_en   <= 1'b0;
         r_mem_w_en   <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (req_valid) begin
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata[15:0];
                  r_rd     <= req_rd;
                  if (w_err != ErrOk) begin
                     r_state      <= StResp;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= '0;
                     r_resp_err   <= w_err;
                     r_resp_rd    <= req_rd;
                  end else if (!req_we) begin
                     r_state    <= StLdRd;
                     r_mem_r_en <= 1'b1;
                  end else if (req_funct3[1:0] == 2'b10) begin
                     r_state     <= StStWr;
                     r_mem_w_en  <= 1'b1;
                     r_mem_wdata <= req_wdata;
                  end else begin
                     r_state    <= StRmwRd;
                     r_mem_r_en <= 1'b1;
                  end
               end
            end
            StLdRd: begin
               r_state    <= StLdCap;
               r_mem_r_en <= 1'b0;
            end
            StLdCap: begin
               r_state      <= StResp;
               r_resp_valid <= 1'b1;
               r_resp_rdata <= w_load;
               r_resp_err   <= ErrOk;
               r_resp_rd    <= r_rd;
            end
            StRmwRd: begin
               r_state    <= StRmwMrg;
               r_mem_r_en <= 1'b0;
            end
            StRmwMrg: begin
               r_state     <= StStWr;
               r_mem_w_en  <= 1'b1;
               r_mem_wdata <= w_merge;
            end
            StStWr: begin
               r_state      <= StResp;
               r_mem_w_en   <= 1'b0;
               r_mem_wdata  <= '0;
               r_resp_valid <= 1'b1;
               r_resp_rdata <= '0;
               r_resp_err   <= ErrOk;
               r_resp_rd    <= r_rd;
            end
            StResp: begin
               r_state <= StIdle;
            end
            default: begin
               r_state     <= StIdle;
               r_mem_r_en  <= 1'b0;
               r_mem_w_en  <= 1'b0;
               r_mem_wdata <= '0;
            end
         endcase
      end
   end

   assign req_ready  = (r_state == StIdle);
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_rd    = r_resp_rd;
   assign resp_err   = r_resp_err;
   assign mem_addr   = (r_state == StIdle) ? 32'd0 : {r_addr[31:2], 2'b00};
   assign mem_wdata  = r_mem_wdata;
   assign mem_r_en   = r_mem_r_en;
   assign mem_w_en   = r_mem_w_en;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table plus back-to-back and mid-op reset sequences.
module tb_lsu_mem_ctrl;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      int          lat;
      logic [31:0] rdata;
      logic [1:0]  err;
      int          ren;
      int          wen;
      logic [31:0] wd;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic [1:0]  resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] mem_rdata;

   logic [31:0] mem [256];
   int total = 0;
   int bad = 0;
   vec_t vecs[$];

   lsu_mem_ctrl #(.DROM_SPACE(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd     (req_rd),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_rd    (resp_rd),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data_memory stand-in: one-cycle read latency, word writes
   always @(posedge clk) begin
      if (mem_w_en) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_r_en) mem_rdata <= mem[mem_addr[9:2]];
   end

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd, input int lat,
                               input logic [31:0] rdata, input logic [1:0] err, input int ren,
                               input int wen, input logic [31:0] wd);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.lat = lat;
      v.rdata = rdata; v.err = err; v.ren = ren; v.wen = wen; v.wd = wd;
      return v;
   endfunction

   task automatic chk(input string nm, input string what, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s %s: got %h want %h", nm, what, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk(nm, "req_ready", 32'(req_ready), 32'd1);
      chk(nm, "resp_valid", 32'(resp_valid), 32'd0);
      chk(nm, "resp_rdata", resp_rdata, 32'd0);
      chk(nm, "resp_rd", 32'(resp_rd), 32'd0);
      chk(nm, "resp_err", 32'(resp_err), 32'd0);
      chk(nm, "mem_r_en", 32'(mem_r_en), 32'd0);
      chk(nm, "mem_w_en", 32'(mem_w_en), 32'd0);
      chk(nm, "mem_addr", mem_addr, 32'd0);
      chk(nm, "mem_wdata", mem_wdata, 32'd0);
   endtask

   task automatic apply(input vec_t v, input string nm);
      int lat = 0;
      int ren = 0;
      int wen = 0;
      logic [31:0] wd = '0;
      logic [31:0] rdata_s = '0;
      logic [1:0] err_s = '0;
      logic [4:0] rd_s = '0;
      bit bad_inv = 0;
      bit bad_addr = 0;
      @(negedge clk);
      chk(nm, "ready_before", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr;
      req_wdata = v.wdata; req_rd = v.rd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         if (n > 1) begin
            @(posedge clk);
            #1;
         end
         if (mem_r_en) ren++;
         if (mem_w_en) begin
            wen++;
            wd = mem_wdata;
         end
         if (mem_r_en && mem_w_en) bad_inv = 1;
         if (!mem_w_en && mem_wdata != 32'd0) bad_inv = 1;
         if ((mem_r_en || mem_w_en) && mem_addr !== {v.addr[31:2], 2'b00}) bad_addr = 1;
         if (resp_valid) begin
            lat = n;
            rdata_s = resp_rdata;
            err_s = resp_err;
            rd_s = resp_rd;
            break;
         end
      end
      chk(nm, "latency", 32'(lat), 32'(v.lat));
      chk(nm, "rdata", rdata_s, v.rdata);
      chk(nm, "err", 32'(err_s), 32'(v.err));
      chk(nm, "rd", 32'(rd_s), 32'(v.rd));
      chk(nm, "r_en_cycles", 32'(ren), 32'(v.ren));
      chk(nm, "w_en_cycles", 32'(wen), 32'(v.wen));
      chk(nm, "wdata", wd, v.wd);
      chk(nm, "en_invariants", 32'(bad_inv), 32'd0);
      chk(nm, "mem_addr", 32'(bad_addr), 32'd0);
      @(posedge clk);
      #1;
      chk(nm, "pulse_one_cycle", 32'(resp_valid), 32'd0);
      chk(nm, "rdata_held", resp_rdata, v.rdata);
      chk(nm, "err_held", 32'(resp_err), 32'(v.err));
      chk(nm, "ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first = 0;
      int second = 0;
      int ren = 0;
      int wen = 0;
      int act = 0;
      bit bad_ready = 0;
      logic [31:0] rd2 = '0;
      logic [31:0] rdata2 = '0;

      // we  f3      addr       wdata         rd  lat  rdata         err ren wen wd
      vecs.push_back(mk(1, 3'b010, 32'h010, 32'h8899AABB, 1, 2, 32'h0, 2'b00, 0, 1, 32'h8899AABB));
      vecs.push_back(mk(0, 3'b000, 32'h011, 32'h0, 2, 3, 32'hFFFFFFAA, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(0, 3'b100, 32'h013, 32'h0, 3, 3, 32'h00000088, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(0, 3'b001, 32'h012, 32'h0, 4, 3, 32'hFFFF8899, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(0, 3'b101, 32'h010, 32'h0, 5, 3, 32'h0000AABB, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(0, 3'b010, 32'h010, 32'h0, 6, 3, 32'h8899AABB, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(1, 3'b000, 32'h012, 32'hDEADBE55, 7, 4, 32'h0, 2'b00, 1, 1, 32'h8855AABB));
      vecs.push_back(mk(0, 3'b010, 32'h010, 32'h0, 8, 3, 32'h8855AABB, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(1, 3'b010, 32'h014, 32'h01020304, 9, 2, 32'h0, 2'b00, 0, 1, 32'h01020304));
      vecs.push_back(mk(1, 3'b001, 32'h016, 32'h1234CAFE, 10, 4, 32'h0, 2'b00, 1, 1, 32'hCAFE0304));
      vecs.push_back(mk(0, 3'b001, 32'h016, 32'h0, 11, 3, 32'hFFFFCAFE, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(1, 3'b010, 32'h3FC, 32'hA5A50F0F, 12, 2, 32'h0, 2'b00, 0, 1, 32'hA5A50F0F));
      vecs.push_back(mk(0, 3'b000, 32'h3FF, 32'h0, 13, 3, 32'hFFFFFFA5, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(0, 3'b010, 32'h102, 32'h0, 14, 1, 32'h0, 2'b01, 0, 0, 32'h0));
      vecs.push_back(mk(1, 3'b010, 32'h3FE, 32'h0, 15, 1, 32'h0, 2'b01, 0, 0, 32'h0));
      vecs.push_back(mk(0, 3'b010, 32'h400, 32'h0, 16, 1, 32'h0, 2'b10, 0, 0, 32'h0));
      vecs.push_back(mk(0, 3'b011, 32'h010, 32'h0, 17, 1, 32'h0, 2'b11, 0, 0, 32'h0));
      vecs.push_back(mk(1, 3'b100, 32'h010, 32'h0, 18, 1, 32'h0, 2'b11, 0, 0, 32'h0));
      vecs.push_back(mk(1, 3'b001, 32'h401, 32'h0, 19, 1, 32'h0, 2'b01, 0, 0, 32'h0));
      vecs.push_back(mk(0, 3'b000, 32'h400, 32'h0, 20, 1, 32'h0, 2'b10, 0, 0, 32'h0));
      vecs.push_back(mk(1, 3'b000, 32'h3FD, 32'h0000003C, 21, 4, 32'h0, 2'b00, 1, 1, 32'hA5A53C0F));
      vecs.push_back(mk(0, 3'b101, 32'h3FE, 32'h0, 22, 3, 32'h0000A5A5, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(0, 3'b010, 32'h3FC, 32'h0, 23, 3, 32'hA5A53C0F, 2'b00, 1, 0, 32'h0));
      vecs.push_back(mk(1, 3'b011, 32'h401, 32'h0, 24, 1, 32'h0, 2'b11, 0, 0, 32'h0));

      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; req_rd = '0;
      #1;
      chk_reset_vals("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Held req_valid: SW 0x20 then LW 0x20 must wait for the store's RESP
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20;
      req_wdata = 32'h13579BDF; req_rd = 5'd25;
      @(posedge clk);
      #1;
      req_we = 1'b0; req_rd = 5'd26; req_wdata = 32'hFFFFFFFF;
      for (int n = 1; n <= 12; n++) begin
         if (n > 1) begin
            @(posedge clk);
            #1;
         end
         if (n <= 6 && req_ready !== (n == 3)) bad_ready = 1;
         if (n == 4) req_valid = 1'b0;
         if (mem_r_en) ren++;
         if (mem_w_en) wen++;
         if (resp_valid) begin
            if (first == 0) begin
               first = n;
            end else if (second == 0) begin
               second = n;
               rdata2 = resp_rdata;
               rd2 = 32'(resp_rd);
            end
         end
      end
      chk("b2b", "first_resp", 32'(first), 32'd2);
      chk("b2b", "second_resp", 32'(second), 32'd6);
      chk("b2b", "rdata", rdata2, 32'h13579BDF);
      chk("b2b", "rd", rd2, 32'd26);
      chk("b2b", "ready_pattern", 32'(bad_ready), 32'd0);
      chk("b2b", "r_en_cycles", 32'(ren), 32'd1);
      chk("b2b", "w_en_cycles", 32'(wen), 32'd1);

      // Reset during RMW_MRG of an SH must abandon the write
      apply(mk(1, 3'b010, 32'h030, 32'h11223344, 27, 2, 32'h0, 2'b00, 0, 1, 32'h11223344),
            "pre_rst");
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h30;
      req_wdata = 32'h00007777; req_rd = 5'd28;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("midrst", "rmw_read", 32'(mem_r_en), 32'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      act = 0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk);
         #1;
         if (resp_valid || mem_w_en || mem_r_en) act++;
      end
      chk("midrst", "no_activity", 32'(act), 32'd0);
      apply(mk(0, 3'b010, 32'h030, 32'h0, 29, 3, 32'h11223344, 2'b00, 1, 0, 32'h0), "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
